cordic_div_scheduler: RTL
=========================

Name: cordic_div_scheduler

Overview:
- Shares one 16-stage pipelined linear CORDIC vectoring unit (computes Z + Y/X, Q2.14) between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake.
- The CORDIC core has no valid signal, so this block tracks in-flight operations with a tag/valid shift register matched to the core latency, and routes each result back with its requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand/result width (signed Q2.14).
- LATENCY, 16, edges from the CORDIC core sampling its inputs to valid X_O/Y_O/Z_O.
- ID_W, 2, requester ID width (= clog2(NUM_REQ)).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready.
- req_x  in  NUM_REQ*DATA_W  divisor per requester, packed (requester i at [i*DATA_W +: DATA_W]).
- req_y  in  NUM_REQ*DATA_W  dividend per requester, packed.
- req_z  in  NUM_REQ*DATA_W  accumulator seed per requester, packed.
- hold  in  1  when 1, no new grants; in-flight operations continue.
- cordic_x, cordic_y, cordic_z  out  DATA_W each  registered operands to the core X_i/Y_i/Z_i.
- cordic_zo  in  DATA_W  core Z_O (the quotient result).
- res_valid  out  1  one-cycle result pulse.
- res_id  out  ID_W  requester ID of the result.
- res_q  out  DATA_W  quotient (registered copy of cordic_zo).
- res_err  out  1  range flag (see Optional Feature).
- inflight  out  5  operations in the pipeline (0..LATENCY+1).
- idle  out  1  inflight==0.

Behaviour:
- Reset values: all outputs 0, except idle=1 and the round-robin pointer, which resets to requester 0. The tag pipeline is cleared.
- Reset mid-operation: all in-flight tags are discarded and no res_valid is produced for them.
- Arbitration: combinational. The winner is the first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[winner]=1 only when hold=0; at most one bit is set.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- On a handshake at edge E:
  - cordic_x/y/z take the winner's operands.
  - Tag {valid=1, id} enters stage 0.
  - rr_ptr becomes (winner+1) mod NUM_REQ.
- With no handshake: cordic_x/y/z hold their values, a bubble (valid=0) enters, and rr_ptr is unchanged.
- Tag pipeline: LATENCY+1 registers deep. The core sees cordic_* from edge E and drives Z_O valid after edge E+LATENCY.
- At edge E+LATENCY+1: res_q<=cordic_zo, res_id<=tag id, res_valid<=tag valid.
  - Handshake-to-res_valid latency is LATENCY+1 cycles.
  - One issue per cycle gives full throughput, and results return in issue order.
- No result backpressure: requesters must accept res_valid in the cycle it is asserted.
- inflight: +1 on a handshake, -1 on res_valid. The same cycle with both leaves it unchanged. It never exceeds LATENCY+1.
- Simultaneous req_valid from all requesters: strict rotation 0,1,2,3,0,… (N back-to-back grants).
- A requester holding req_valid continuously is granted at most once per NUM_REQ cycles while others are requesting. It is granted every cycle when it is alone.
- hold asserted for k cycles: no grants and rr_ptr frozen. The pipeline drains and idle asserts LATENCY+1 cycles after the last handshake.
- Arithmetic: none on the datapath; operands pass through unchanged, with sign extension not applicable.

Optional Feature:
- Macro: CORDIC_DIV_RANGE_CHECK_EN.
- When defined:
  - At issue, flag err if x==0 or |y| >= 2·|x|. This is outside the linear-vectoring convergence range, and the quotient would reach or exceed 2.0 = 32768, which is unrepresentable in Q2.14.
  - Magnitudes are compared at DATA_W+1 bits, so -32768 is handled.
  - err travels with the tag; res_err equals the tag's err in the res_valid cycle and is 0 otherwise.
  - Flagged operations are still issued and res_q passes through unmodified.
- When undefined: res_err is tied 0 and no comparators exist.

Decomposition:
- Package cordic_div_pkg:
  - Q2.14 constants ONE_Q=16384, HALF_Q=8192.
  - Tag struct {valid, id, err}.
  - Default LATENCY=16.
- Sub-module rr_arbiter (NUM_REQ-wide round-robin with pointer, hold, one-hot grant) is natural.
- Tag shift register and result mux live in the top.

Test Plan:
- Single request, requester 2: x=16384, y=8192, z=0 → req_ready[2] same cycle. After LATENCY+1=17 cycles: res_valid=1, res_id=2, res_q=8192±2, res_err=0.
- All 4 requesters valid every cycle for 8 cycles → grants in order 0,1,2,3,0,1,2,3. Results return in the same ID order on 8 consecutive cycles; inflight peaks at 8.
- Negative and offset operands:
  - x=8192, y=-4096, z=0 → res_q=-8192±2.
  - x=13107, y=6554, z=1638 → res_q=9830±3.
- Range check (macro defined):
  - x=8192, y=16384 → res_err=1.
  - x=0, y=100 → res_err=1.
  - x=16384, y=12288 → res_err=0, res_q=12288±2.
- hold=1 with requests pending for 20 cycles → no req_ready; idle=1 by cycle 17; releasing hold grants from the unchanged rr_ptr.
- reset asserted with 5 operations in flight → all outputs 0 and idle=1 immediately; no res_valid in the following 20 cycles.

Source files
------------

// File: rtl/cordic_div_pkg.sv
// Shared types and constants for the CORDIC divider scheduler.
package cordic_div_pkg;

  localparam int ONE_Q       = 16384;
  localparam int HALF_Q      = 8192;
  localparam int LATENCY_DEF = 16;
  localparam int ID_MAX_W    = 3;

  // id is sized for the largest supported requester count (8)
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic                err;
  } tag_t;

endpackage

// File: rtl/cordic_div_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a rotating
// pointer, suppressed by hold; the pointer advances past each winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               fire
);

  logic [ID_W-1:0] ptr;
  logic            found;

  always_comb begin
    logic [ID_W-1:0] sel;
    found  = 1'b0;
    winner = '0;
    sel    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && valid[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  // grants are masked during reset so every output reads 0 while it is held
  assign fire = found & ~hold & ~reset;

  always_comb begin
    grant = '0;
    if (fire) grant[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ptr <= '0;
    else if (fire) ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
  end

endmodule

// File: rtl/cordic_div_scheduler.sv
// Shares one pipelined linear CORDIC divider among NUM_REQ requesters and tracks
// in-flight ops with a tag pipeline. Optional range flag: CORDIC_DIV_RANGE_CHECK_EN.
module cordic_div_scheduler
  import cordic_div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int LATENCY = LATENCY_DEF,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  input  logic [NUM_REQ*DATA_W-1:0] req_z,
  input  logic                      hold,
  output logic [DATA_W-1:0]         cordic_x,
  output logic [DATA_W-1:0]         cordic_y,
  output logic [DATA_W-1:0]         cordic_z,
  input  logic [DATA_W-1:0]         cordic_zo,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [DATA_W-1:0]         res_q,
  output logic                      res_err,
  output logic [4:0]                inflight,
  output logic                      idle
);

  logic [ID_W-1:0]   winner;
  logic              fire;
  logic              issue_err;
  logic [DATA_W-1:0] sel_x, sel_y, sel_z;
  tag_t              tags [LATENCY+1];
  logic              unused_tag;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  (req_valid),
    .hold   (hold),
    .grant  (req_ready),
    .winner (winner),
    .fire   (fire)
  );

  assign sel_x = req_x[int'(winner)*DATA_W +: DATA_W];
  assign sel_y = req_y[int'(winner)*DATA_W +: DATA_W];
  assign sel_z = req_z[int'(winner)*DATA_W +: DATA_W];

`ifdef CORDIC_DIV_RANGE_CHECK_EN
  // one extra bit so |-32768| is representable
  logic [DATA_W:0]   mag_x, mag_y;
  logic [DATA_W+1:0] twice_x;
  always_comb begin
    mag_x     = sel_x[DATA_W-1] ? (~{1'b1, sel_x} + 1'b1) : {1'b0, sel_x};
    mag_y     = sel_y[DATA_W-1] ? (~{1'b1, sel_y} + 1'b1) : {1'b0, sel_y};
    twice_x   = {mag_x, 1'b0};
    issue_err = (sel_x == '0) || ({1'b0, mag_y} >= twice_x);
  end
`else
  assign issue_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cordic_x <= '0;
      cordic_y <= '0;
      cordic_z <= '0;
    end else if (fire) begin
      cordic_x <= sel_x;
      cordic_y <= sel_y;
      cordic_z <= sel_z;
    end
  end

  // the core has no valid, so the tag delay must equal its latency plus one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: fire, id: ID_MAX_W'(winner), err: fire & issue_err};
      for (int i = 1; i <= LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_q     <= '0;
      inflight  <= '0;
    end else begin
      res_valid <= tags[LATENCY].valid;
      res_id    <= tags[LATENCY].id[ID_W-1:0];
      if (tags[LATENCY].valid) res_q <= cordic_zo;
      inflight  <= inflight + 5'(fire) - 5'(tags[LATENCY].valid);
    end
  end

`ifdef CORDIC_DIV_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) res_err <= 1'b0;
    else       res_err <= tags[LATENCY].valid & tags[LATENCY].err;
  end
`else
  assign res_err = 1'b0;
`endif

  assign idle       = (inflight == 5'd0);
  assign unused_tag = ^{tags[LATENCY].id, tags[LATENCY].err};

endmodule
